// File: rtl/axis_pkt_demux.sv
// -----------------------------------------------------------------------------
// axis_pkt_demux
//
// Packet-aware AXI-Stream demultiplexer. The route index is taken from
// select_committed on the first accepted beat of each packet and held until
// that packet's tlast beat is accepted, so a packet is never split across
// masters. One output register stage; payload is a shared bus and only the
// per-master tvalid differs between outputs. Packets whose route is
// out of range are consumed at full rate and counted in drop_count.
//
// Ports
//   axis_aclk          clock
//   axis_rst           synchronous active-high reset
//   select_committed   route index, sampled on the first beat of a packet
//   s_axis_*           slave stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   m_axis_tvalid      per-master valid, one-hot or zero
//   m_axis_tready      per-master ready
//   m_axis_t{data,keep,last,user}  shared payload to all masters
//   busy               high while a packet is in progress
//   drop_count         saturating count of dropped packets
// -----------------------------------------------------------------------------
module axis_pkt_demux #(
    parameter int M_COUNT    = 2,
    parameter int CL_M_COUNT = $clog2(M_COUNT),
    parameter int DATA_W     = 512,
    parameter int USER_W     = 48,
    localparam int KEEP_W    = DATA_W / 8
) (
    input  logic                  axis_aclk,
    input  logic                  axis_rst,
    input  logic [CL_M_COUNT-1:0] select_committed,

    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [KEEP_W-1:0]     s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [USER_W-1:0]     s_axis_tuser,

    output logic [M_COUNT-1:0]    m_axis_tvalid,
    input  logic [M_COUNT-1:0]    m_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [KEEP_W-1:0]     m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_W-1:0]     m_axis_tuser,

    output logic                  busy,
    output logic [31:0]           drop_count
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    logic [0:0]            state;
    logic [CL_M_COUNT-1:0] route_sel;
    logic [CL_M_COUNT-1:0] eff_sel;
    logic                  eff_drop;
    logic [M_COUNT-1:0]    sel_onehot;
    logic [M_COUNT-1:0]    out_vld;
    logic                  out_ready;
    logic                  s_accept;

    // At a packet boundary the live select decides the route of the beat
    // being offered; inside a packet the latched route wins.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        eff_sel = route_sel;
        if (state == ST_IDLE) begin
            eff_sel = select_committed;
        end
    end

    assign eff_drop   = 32'(eff_sel) >= 32'(M_COUNT);
    assign sel_onehot = M_COUNT'(1) << eff_sel;

    // out_vld is non-zero only on the held beat's master, so ANDing with the
    // ready vector picks ready[out_sel] and ignores the other masters.
    assign out_ready  = |(out_vld & m_axis_tready);

    // Dropped beats never touch the output register, so they are accepted
    // regardless of whether a previous beat is still held.
    assign s_axis_tready = !axis_rst && (eff_drop || (out_vld == '0) || out_ready);
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state      <= ST_IDLE;
            route_sel  <= '0;
            out_vld    <= '0;
            drop_count <= '0;
        end else begin
            // A new beat may overwrite the register only when it is empty or
            // draining this cycle, which s_axis_tready already guarantees.
            if (s_accept && !eff_drop) begin
                out_vld <= sel_onehot;
            end else if (out_ready) begin
                out_vld <= '0;
            end

            if (s_accept) begin
                if (state == ST_IDLE) begin
                    route_sel <= select_committed;
                    state     <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
                end else if (s_axis_tlast) begin
                    state <= ST_IDLE;
                end

                if (eff_drop && s_axis_tlast && (drop_count != '1)) begin
                    drop_count <= drop_count + 32'd1;
                end
            end
        end
    end

    // NOTE: the payload register is deliberately not reset; it is qualified
    // by out_vld, and leaving it out of reset keeps the wide datapath cheap.
    always_ff @(posedge axis_aclk) begin
        if (s_accept && !eff_drop) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast;
            m_axis_tuser <= s_axis_tuser;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign busy          = (state == ST_IN_PKT);

endmodule

// File: tb/tb_axis_pkt_demux.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_demux
//
// Bench for axis_pkt_demux with three masters, so select value 3 is out of
// range. Inputs change on the falling edge; outputs are sampled 1 ns later.
// The reference model tracks packet boundaries, the route of the current
// packet, the queue of beats owed to the masters and the expected drop count.
// -----------------------------------------------------------------------------
module tb_axis_pkt_demux;

    localparam int M  = 3;
    localparam int CL = 2;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int KW = DW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [CL-1:0]  sel;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic [KW-1:0]  s_keep;
    logic           s_last;
    logic [UW-1:0]  s_user;
    logic [M-1:0]   m_valid;
    logic [M-1:0]   m_ready;
    logic [DW-1:0]  m_data;
    logic [KW-1:0]  m_keep;
    logic           m_last;
    logic [UW-1:0]  m_user;
    logic           busy;
    logic [31:0]    drop_count;

    always #5 clk = ~clk;

    axis_pkt_demux #(
        .M_COUNT    (M),
        .CL_M_COUNT (CL),
        .DATA_W     (DW),
        .USER_W     (UW)
    ) dut (
        .axis_aclk        (clk),
        .axis_rst         (rst),
        .select_committed (sel),
        .s_axis_tvalid    (s_valid),
        .s_axis_tready    (s_ready),
        .s_axis_tdata     (s_data),
        .s_axis_tkeep     (s_keep),
        .s_axis_tlast     (s_last),
        .s_axis_tuser     (s_user),
        .m_axis_tvalid    (m_valid),
        .m_axis_tready    (m_ready),
        .m_axis_tdata     (m_data),
        .m_axis_tkeep     (m_keep),
        .m_axis_tlast     (m_last),
        .m_axis_tuser     (m_user),
        .busy             (busy),
        .drop_count       (drop_count)
    );

    typedef struct {
        int            mst;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    // reference model state
    beat_t   exp_q[$];
    bit      mdl_idle = 1'b1;
    int      mdl_route = 0;
    int      exp_drop = 0;
    bit      prev_rst = 1'b0;
    bit      prev_held = 1'b0;
    logic [M-1:0]  prev_valid;
    logic [DW-1:0] prev_data;
    logic [KW+UW:0] prev_side;

    int      n_checks = 0;
    int      n_fail = 0;
    bit      acc;
    int      last_cycles;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called mid-cycle: compares outputs against the model, then folds this
    // cycle's input acceptance into the model.
    task automatic monitor();
        int      route_now;
        bit      drop;
        bit      xfer;
        beat_t   b;
        logic [M-1:0] exp_v;
        acc = 1'b0;
        if (rst) begin
            if (prev_rst) begin
                check("rst_tvalid", 64'(m_valid), 64'(0));
                check("rst_tready", 64'(s_ready), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_drop", 64'(drop_count), 64'(0));
            end
            exp_q.delete();
            mdl_idle  = 1'b1;
            exp_drop  = 0;
            prev_held = 1'b0;
            prev_rst  = 1'b1;
            return;
        end
        prev_rst = 1'b0;

        check("onehot", 64'($countones(m_valid) <= 1), 64'(1));
        check("valid_vs_model", 64'(m_valid != '0), 64'(exp_q.size() != 0));
        check("busy", 64'(busy), 64'(!mdl_idle));
        check("drop_count", 64'(drop_count), 64'(exp_drop));

        if (prev_held) begin
            check("hold_valid", 64'(m_valid), 64'(prev_valid));
            check("hold_data", m_data, prev_data);
            check("hold_side", 64'({m_keep, m_last, m_user}), 64'(prev_side));
        end

        prev_held = 1'b0;
        if (m_valid != '0 && exp_q.size() != 0) begin
            b     = exp_q[0];
            exp_v = M'(1) << b.mst;
            check("out_master", 64'(m_valid), 64'(exp_v));
            xfer = (m_valid & m_ready) != '0;
            if (xfer) begin
                check("out_data", m_data, b.data);
                check("out_side", 64'({m_keep, m_last, m_user}), 64'({b.keep, b.last, b.user}));
                void'(exp_q.pop_front());
            end else begin
                prev_held  = 1'b1;
                prev_valid = m_valid;
                prev_data  = m_data;
                prev_side  = {m_keep, m_last, m_user};
            end
        end

        route_now = mdl_idle ? int'(sel) : mdl_route;
        drop      = route_now >= M;
        if (s_valid) begin
            check("s_tready", 64'(s_ready),
                  64'(drop || (m_valid == '0) || ((m_valid & m_ready) != '0)));
        end
        acc = s_valid && s_ready;
        if (acc) begin
            if (mdl_idle) mdl_route = route_now;
            if (drop) begin
                if (s_last) exp_drop++;
            end else begin
                b.mst  = route_now;
                b.data = s_data;
                b.keep = s_keep;
                b.last = s_last;
                b.user = s_user;
                exp_q.push_back(b);
            end
            mdl_idle = s_last;
        end
    endtask

    // Enter at a falling edge with inputs set; return at the next falling edge.
    task automatic step();
        #1;
        monitor();
        @(negedge clk);
    endtask

    // rdy_mode: 0 all ready, 1 random, 2 master 0 ready follows 1,0,0,1
    task automatic send_pkt(input int sel0, input int sel1, input int chg, input int n,
                            input int rdy_mode, input int gap_pct, input bit rand_sel,
                            input int stop_after);
        int beat = 0;
        int cyc  = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (beat < stop_after) begin
            if (rand_sel) sel = CL'($urandom_range(0, 3));
            else          sel = CL'((beat >= chg) ? sel1 : sel0);
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = {$urandom, $urandom};
            s_keep  = KW'($urandom);
            s_user  = UW'($urandom);
            s_last  = (beat == n - 1);
            case (rdy_mode)
                0:       m_ready = '1;
                1:       m_ready = M'($urandom);
                default: m_ready = {2'b11, pat[cyc % 4]};
            endcase
            step();
            if (acc) beat++;
            cyc++;
            if (cyc > 500) begin
                check("timeout", 64'(0), 64'(1));
                break;
            end
        end
        last_cycles = cyc;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = '1;
        sel     = '0;
        repeat (n) step();
    endtask

    initial begin
        int tot;
        rst = 1'b1; sel = '0; s_valid = 1'b0; s_data = '0; s_keep = '0;
        s_last = 1'b0; s_user = '0; m_ready = '0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // packet to master 1, all ready
        send_pkt(1, 1, 99, 4, 0, 0, 0, 4);
        check("pkt1_rate", 64'(last_cycles), 64'(4));
        idle(2);

        // select moves mid-packet; next packet uses the new select
        send_pkt(0, 1, 2, 5, 0, 0, 0, 5);
        send_pkt(1, 1, 99, 3, 0, 0, 0, 3);
        idle(2);

        // master 0 ready toggles during the packet
        send_pkt(0, 0, 99, 4, 2, 0, 0, 4);
        idle(2);

        // out-of-range route: two packets dropped at full rate
        send_pkt(3, 3, 99, 3, 1, 0, 0, 3);
        check("drop_rate_a", 64'(last_cycles), 64'(3));
        send_pkt(3, 3, 99, 3, 1, 0, 0, 3);
        check("drop_rate_b", 64'(last_cycles), 64'(3));
        idle(1);
        check("drop_total", 64'(drop_count), 64'(2));

        // reset after beat 2 of 4, then a single-beat packet to master 0
        send_pkt(0, 0, 99, 4, 0, 0, 0, 2);
        rst = 1'b1; s_valid = 1'b0; m_ready = '0;
        repeat (2) step();
        rst = 1'b0;
        send_pkt(0, 0, 99, 1, 0, 0, 0, 1);
        check("post_rst_rate", 64'(last_cycles), 64'(1));
        idle(3);
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_drop", 64'(drop_count), 64'(0));

        // alternating single-beat packets, full throughput
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send_pkt(i % 2, i % 2, 99, 1, 0, 0, 0, 1);
            tot += last_cycles;
        end
        check("alt_rate", 64'(tot), 64'(4));
        idle(2);

        // randomized traffic: random lengths, gaps, readies and select
        for (int p = 0; p < 60; p++) begin
            int n;
            n = $urandom_range(1, 5);
            send_pkt(0, 0, 99, n, 1, 25, 1, n);
        end
        idle(5);
        check("drained", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
